// File: rtl/matmul_sched.sv
// Job sequencer for one matmul engine: queues job descriptors, launches them one at a time,
// holds the engine inputs, reports tagged completions and halts dispatch on a ret timeout.
module matmul_sched #(
    parameter int unsigned MEM_AW   = 16,
    parameter int unsigned DIM_BITS = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned TMO_W    = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                job_vld,
    output logic                job_rdy,
    input  logic [TAG_W-1:0]    job_tag,
    input  logic [MEM_AW-1:0]   job_a_base,
    input  logic [MEM_AW-1:0]   job_b_base,
    input  logic [MEM_AW-1:0]   job_c_base,
    input  logic [DIM_BITS-1:0] job_a_stride,
    input  logic [DIM_BITS-1:0] job_b_stride,
    input  logic [DIM_BITS-1:0] job_c_stride,
    input  logic [DIM_BITS-1:0] job_a_rows,
    input  logic [DIM_BITS-1:0] job_a_cols,
    input  logic [DIM_BITS-1:0] job_b_cols,
    output logic [MEM_AW-1:0]   aBASE,
    output logic [MEM_AW-1:0]   bBASE,
    output logic [MEM_AW-1:0]   cBASE,
    output logic [DIM_BITS-1:0] aSTRIDE,
    output logic [DIM_BITS-1:0] bSTRIDE,
    output logic [DIM_BITS-1:0] cSTRIDE,
    output logic [DIM_BITS-1:0] aROWS,
    output logic [DIM_BITS-1:0] aCOLS,
    output logic [DIM_BITS-1:0] bCOLS,
    output logic                go,
    input  logic                ret,
    output logic                done_vld,
    input  logic                done_rdy,
    output logic [TAG_W-1:0]    done_tag,
    output logic                done_err,
    output logic                halted,
    input  logic                clr_halt,
    output logic                busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_POST   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [MEM_AW-1:0]   a_base;
        logic [MEM_AW-1:0]   b_base;
        logic [MEM_AW-1:0]   c_base;
        logic [DIM_BITS-1:0] a_stride;
        logic [DIM_BITS-1:0] b_stride;
        logic [DIM_BITS-1:0] c_stride;
        logic [DIM_BITS-1:0] a_rows;
        logic [DIM_BITS-1:0] a_cols;
        logic [DIM_BITS-1:0] b_cols;
    } job_t;

    job_t             mem [DEPTH];
    job_t             wr_job;
    job_t             head;
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [2:0]       state, state_nxt;
    logic [TMO_W-1:0] cnt, cnt_nxt;
    logic             push, pop, empty, full_nxt, err_nxt;

    assign wr_job = '{tag: job_tag, a_base: job_a_base, b_base: job_b_base, c_base: job_c_base,
                      a_stride: job_a_stride, b_stride: job_b_stride, c_stride: job_c_stride,
                      a_rows: job_a_rows, a_cols: job_a_cols, b_cols: job_b_cols};
    assign head     = mem[rd_ptr[AW-1:0]];
    assign push     = job_vld && job_rdy;
    assign empty    = (wr_ptr == rd_ptr);
    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign full_nxt = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) && (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        cnt_nxt   = cnt;
        err_nxt   = done_err;
        case (state)
            S_IDLE: begin
                if (!empty && !halted) begin
                    pop       = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_nxt   = '0;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                cnt_nxt = cnt + TMO_W'(1);
                // ret takes priority over a timeout landing in the same cycle.
                if (ret) begin
                    err_nxt   = 1'b0;
                    state_nxt = S_POST;
                end else if (cnt == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_POST;
                end
            end
            S_POST: begin
                if (done_rdy) state_nxt = done_err ? S_HALT : S_IDLE;
            end
            S_HALT: begin
                if (clr_halt) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        wr_ptr_nxt = wr_ptr + PW'(push);
        rd_ptr_nxt = rd_ptr + PW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered outputs, FIFO pointers and the active-job engine registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            job_rdy  <= 1'b0;
            go       <= 1'b0;
            done_vld <= 1'b0;
            done_tag <= '0;
            done_err <= 1'b0;
            halted   <= 1'b0;
            busy     <= 1'b0;
            aBASE    <= '0;
            bBASE    <= '0;
            cBASE    <= '0;
            aSTRIDE  <= '0;
            bSTRIDE  <= '0;
            cSTRIDE  <= '0;
            aROWS    <= '0;
            aCOLS    <= '0;
            bCOLS    <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            job_rdy  <= !full_nxt;
            go       <= (state_nxt == S_LAUNCH);
            done_vld <= (state_nxt == S_POST);
            done_err <= err_nxt;
            halted   <= (state_nxt == S_HALT);
            busy     <= (state_nxt != S_IDLE) || (wr_ptr_nxt != rd_ptr_nxt);
            if (pop) begin
                done_tag <= head.tag;
                aBASE    <= head.a_base;
                bBASE    <= head.b_base;
                cBASE    <= head.c_base;
                aSTRIDE  <= head.a_stride;
                bSTRIDE  <= head.b_stride;
                cSTRIDE  <= head.c_stride;
                aROWS    <= head.a_rows;
                aCOLS    <= head.a_cols;
                bCOLS    <= head.b_cols;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_job;
    end

endmodule

// File: tb/tb_matmul_sched.sv
// Self-checking bench for matmul_sched: table of single jobs plus hand-written halt,
// backpressure and reset sequences; completions are checked against a scoreboard queue.
module tb_matmul_sched;

    localparam int unsigned MEM_AW   = 16;
    localparam int unsigned DIM_BITS = 16;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned TMO_W    = 5;

    logic                clk, rst_n, job_vld, job_rdy, go, ret, done_vld, done_rdy;
    logic                done_err, halted, clr_halt, busy;
    logic [TAG_W-1:0]    job_tag, done_tag;
    logic [MEM_AW-1:0]   job_a_base, job_b_base, job_c_base, aBASE, bBASE, cBASE;
    logic [DIM_BITS-1:0] job_a_stride, job_b_stride, job_c_stride;
    logic [DIM_BITS-1:0] job_a_rows, job_a_cols, job_b_cols;
    logic [DIM_BITS-1:0] aSTRIDE, bSTRIDE, cSTRIDE, aROWS, aCOLS, bCOLS;

    matmul_sched #(.MEM_AW(MEM_AW), .DIM_BITS(DIM_BITS), .DEPTH(DEPTH), .TAG_W(TAG_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst_n(rst_n), .job_vld(job_vld), .job_rdy(job_rdy), .job_tag(job_tag),
        .job_a_base(job_a_base), .job_b_base(job_b_base), .job_c_base(job_c_base),
        .job_a_stride(job_a_stride), .job_b_stride(job_b_stride), .job_c_stride(job_c_stride),
        .job_a_rows(job_a_rows), .job_a_cols(job_a_cols), .job_b_cols(job_b_cols),
        .aBASE(aBASE), .bBASE(bBASE), .cBASE(cBASE), .aSTRIDE(aSTRIDE), .bSTRIDE(bSTRIDE),
        .cSTRIDE(cSTRIDE), .aROWS(aROWS), .aCOLS(aCOLS), .bCOLS(bCOLS), .go(go), .ret(ret),
        .done_vld(done_vld), .done_rdy(done_rdy), .done_tag(done_tag), .done_err(done_err),
        .halted(halted), .clr_halt(clr_halt), .busy(busy)
    );

    typedef struct {
        int tag;
        int rows;
        int cols;
        int bcols;
        int dly;
        bit err;
    } vec_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t         exp_q[$];
    int           n_chk = 0;
    int           n_err = 0;
    int           go_cnt = 0;
    int           eng_cnt = -1;
    int           ret_delay = -1;
    int           go_base;
    logic         go_prev = 1'b0;
    logic [143:0] exp_eng;
    logic [143:0] eng;
    logic [153:0] all_out;

    assign eng     = {aBASE, bBASE, cBASE, aSTRIDE, bSTRIDE, cSTRIDE, aROWS, aCOLS, bCOLS};
    assign all_out = {job_rdy, eng, go, done_vld, done_tag, done_err, halted, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Engine model: ret pulses ret_delay cycles after the go cycle; negative delay never returns.
    initial begin
        ret = 1'b0;
        forever begin
            @(posedge clk); #1;
            ret = 1'b0;
            if (!rst_n) begin
                eng_cnt = -1;
            end else begin
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) ret = 1'b1;
                end
                if (go) begin
                    go_cnt++;
                    eng_cnt = ret_delay;
                end
            end
        end
    end

    // Completion scoreboard and go pulse-width monitor.
    always @(negedge clk) begin
        if (rst_n && go) chk("go_width", 160'(go_prev), 160'(0));
        go_prev = go;
        if (rst_n && done_vld && done_rdy) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_done: got tag %0h, expected no completion", done_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_tag", 160'(done_tag), 160'(e.tag));
                chk("done_err", 160'(done_err), 160'(e.err));
            end
        end
    end

    task automatic drive_job(input int tag, input int rows, input int cols, input int bcols, input bit err);
        int n = 0;
        while (!job_rdy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("job_rdy_wait", 160'(job_rdy), 160'(1));
        job_vld      = 1'b1;
        job_tag      = TAG_W'(tag);
        job_a_base   = MEM_AW'(32'h1000 + tag);
        job_b_base   = MEM_AW'(32'h2000 + tag * 3);
        job_c_base   = MEM_AW'(32'h3000 + tag * 5);
        job_a_stride = DIM_BITS'(rows * 2 + 1);
        job_b_stride = DIM_BITS'(cols * 2 + 3);
        job_c_stride = DIM_BITS'(bcols * 2 + 5);
        job_a_rows   = DIM_BITS'(rows);
        job_a_cols   = DIM_BITS'(cols);
        job_b_cols   = DIM_BITS'(bcols);
        exp_eng = {job_a_base, job_b_base, job_c_base, job_a_stride, job_b_stride, job_c_stride,
                   job_a_rows, job_a_cols, job_b_cols};
        exp_q.push_back('{tag: TAG_W'(tag), err: err});
        @(posedge clk); #1;
        job_vld = 1'b0;
    endtask

    task automatic wait_go();
        int n = 0;
        @(negedge clk);
        while (!go && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("go_seen", 160'(go), 160'(1));
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done_vld && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 160'(done_vld), 160'(1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 160'(exp_q.size()), 160'(0));
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1;
        clr_halt = 1'b1;
        @(posedge clk); #1;
        clr_halt = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        // tag, rows, cols, bcols, ret delay after go, expected err
        vecs[0] = '{tag: 3,  rows: 2, cols: 2, bcols: 2,  dly: 20, err: 1'b0};
        vecs[1] = '{tag: 5,  rows: 0, cols: 0, bcols: 0,  dly: 1,  err: 1'b0};
        vecs[2] = '{tag: 7,  rows: 8, cols: 4, bcols: 16, dly: 31, err: 1'b0};
        vecs[3] = '{tag: 12, rows: 3, cols: 3, bcols: 3,  dly: 32, err: 1'b1};
        vecs[4] = '{tag: 1,  rows: 1, cols: 1, bcols: 1,  dly: 30, err: 1'b0};

        rst_n = 1'b1; job_vld = 1'b0; done_rdy = 1'b1; clr_halt = 1'b0;
        job_tag = '0; job_a_base = '0; job_b_base = '0; job_c_base = '0;
        job_a_stride = '0; job_b_stride = '0; job_c_stride = '0;
        job_a_rows = '0; job_a_cols = '0; job_b_cols = '0;
        #2 rst_n = 1'b0;

        @(negedge clk);
        chk("reset_outputs", 160'(all_out), 160'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("job_rdy_before_edge", 160'(job_rdy), 160'(0));
        @(negedge clk);
        chk("job_rdy_after_reset", 160'(job_rdy), 160'(1));

        // Single jobs one at a time, including the ret/timeout boundary.
        for (int i = 0; i < 5; i++) begin
            ret_delay = vecs[i].dly;
            drive_job(vecs[i].tag, vecs[i].rows, vecs[i].cols, vecs[i].bcols, vecs[i].err);
            wait_go();
            @(negedge clk);
            chk("engine_regs_run", 160'(eng), 160'(exp_eng));
            wait_done();
            @(negedge clk);
            chk("halted_after_job", 160'(halted), 160'(vecs[i].err));
            chk("done_vld_cleared", 160'(done_vld), 160'(0));
            chk("engine_regs_held", 160'(eng), 160'(exp_eng));
            if (vecs[i].err) clr_pulse();
            if (vecs[i].err) @(negedge clk);
            chk("idle_not_busy", 160'({halted, busy}), 160'(0));
        end

        // Timeout halts dispatch; FIFO fills while halted, drains in order after clr_halt.
        ret_delay = -1;
        drive_job(13, 2, 2, 2, 1'b1);
        wait_go();
        wait_done();
        @(negedge clk);
        chk("halted_on_timeout", 160'(halted), 160'(1));
        go_base = go_cnt;
        ret_delay = 3;
        for (int t = 0; t < DEPTH; t++) drive_job(t, t + 1, 2, 3, 1'b0);
        @(negedge clk);
        chk("fifo_full_rdy", 160'(job_rdy), 160'(0));
        chk("busy_halted", 160'(busy), 160'(1));
        repeat (10) @(negedge clk);
        chk("no_launch_in_halt", 160'(go_cnt), 160'(go_base));
        chk("still_halted", 160'(halted), 160'(1));
        clr_pulse();
        @(negedge clk);
        chk("halt_cleared", 160'(halted), 160'(0));
        drive_job(DEPTH, 4, 4, 4, 1'b0);
        wait_drain();
        chk("launch_count", 160'(go_cnt), 160'(go_base + DEPTH + 1));

        // Completion held by done_rdy=0: outputs stable and no next launch.
        done_rdy = 1'b0;
        ret_delay = 2;
        drive_job(9, 2, 3, 4, 1'b0);
        drive_job(10, 5, 6, 7, 1'b0);
        wait_done();
        go_base = go_cnt;
        repeat (10) begin
            @(negedge clk);
            chk("post_hold", 160'({done_vld, done_tag, done_err}), 160'({1'b1, 4'd9, 1'b0}));
        end
        chk("no_go_in_post", 160'(go_cnt), 160'(go_base));
        @(posedge clk); #1;
        done_rdy = 1'b1;
        wait_drain();
        chk("second_launch", 160'(go_cnt), 160'(go_base + 1));

        // Reset during RUN with jobs queued: everything flushes.
        ret_delay = 25;
        drive_job(2, 1, 1, 1, 1'b0);
        drive_job(6, 1, 1, 1, 1'b0);
        drive_job(8, 1, 1, 1, 1'b0);
        wait_go();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_mid_job", 160'(all_out), 160'(0));
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        go_base = go_cnt;
        repeat (20) @(negedge clk);
        chk("no_go_after_reset", 160'(go_cnt), 160'(go_base));
        chk("flushed_state", 160'({busy, done_vld, halted, job_rdy}), 160'(4'b0001));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion of test sequence");
        $fatal(1, "watchdog");
    end

endmodule
